// File: rtl/output_load_seq.sv
// Load sequencer behind the output buffer: walks group indices,
// captures returned words and queues them in a small FWFT FIFO.
module output_load_seq #(
    parameter int NUM_GROUPS = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  load_mode_i,
    output logic        load_en_o,
    output logic [5:0]  load_cnt_o,
    output logic [1:0]  load_mode_o,
    input  logic [31:0] out_buf_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic        busy_o,
    output logic        done_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NUM_GROUPS + 1);

    localparam logic [5:0]    LAST_GRP = 6'(NUM_GROUPS - 1);
    localparam logic [CW-1:0] N_GRP    = CW'(NUM_GROUPS);
    localparam logic [CW-1:0] N_ONE    = CW'(1);
    localparam logic [AW+1:0] DEPTH_X  = (AW + 2)'(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [1:0]    mode_q;
    logic [5:0]    icnt_q;
    logic [5:0]    cnt_q;
    logic [CW-1:0] acnt_q;
    logic          pend_q;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   fcnt_q;

    logic          mode1;
    logic          start_ok;
    logic          space;
    logic          issue;
    logic          last_issue;
    logic          all_acc;
    logic          push;
    logic          pop;
    logic          full;
    logic [AW+1:0] occ;
    logic [5:0]    last_idx;
    logic [CW-1:0] n_words;

    assign mode1    = mode_q == 2'd1;
    assign start_ok = start_i && (load_mode_i != 2'd0);
    assign last_idx = mode1 ? 6'd0 : LAST_GRP;
    assign n_words  = mode1 ? N_ONE : N_GRP;

    // Words already queued plus the one still in flight from the buffer.
    assign occ   = {1'b0, fcnt_q} + {{(AW + 1){1'b0}}, pend_q};
    assign space = occ < DEPTH_X;

    assign issue      = (state_q == ISSUE) && space;
    assign last_issue = issue && (icnt_q == last_idx);
    assign all_acc    = acnt_q == n_words;

    // Mode 1 data is valid alongside the strobe; group modes lag one cycle.
    assign push = mode1 ? issue : pend_q;
    assign pop  = rvalid_o && rready_i;
    assign full = fcnt_q == DEPTH_C;

    assign rvalid_o    = fcnt_q != '0;
    assign rdata_o     = rvalid_o ? mem_q[rptr_q] : 32'd0;
    assign load_mode_o = mode_q;
    assign load_cnt_o  = issue ? icnt_q : cnt_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (all_acc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        load_en_o = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_o = 1'b0;
            end
            ISSUE: begin
                busy_o    = 1'b1;
                load_en_o = space;
            end
            DRAIN: begin
                busy_o = 1'b1;
                done_o = all_acc;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    // Mode latch plus issue and accept counters for the running sequence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= 2'd0;
            icnt_q <= 6'd0;
            acnt_q <= '0;
        end else if ((state_q == IDLE) && start_ok) begin
            mode_q <= load_mode_i;
            icnt_q <= 6'd0;
            acnt_q <= '0;
        end else begin
            if (issue) begin
                icnt_q <= icnt_q + 6'd1;
            end
            if (pop && (state_q != IDLE)) begin
                acnt_q <= acnt_q + 1'b1;
            end
        end
    end

    // Last issued index and the one-cycle in-flight flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 6'd0;
            pend_q <= 1'b0;
        end else begin
            if (issue) begin
                cnt_q <= icnt_q;
            end
            pend_q <= issue && !mode1;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fcnt_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                fcnt_q <= fcnt_q + 1'b1;
            end else if (!push && pop) begin
                fcnt_q <= fcnt_q - 1'b1;
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (push) begin
            mem_q[wptr_q] <= out_buf_i;
        end
    end

    // Issue gating must keep the FIFO from ever being written while full.
    push_when_full_a : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(push && full)
    );

endmodule

// File: tb/tb_output_load_seq.sv
// Scoreboard bench for output_load_seq: directed sequences,
// output buffer model and a decoupled pop monitor.
module tb_output_load_seq;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  load_mode_i;
    logic        load_en_o;
    logic [5:0]  load_cnt_o;
    logic [1:0]  load_mode_o;
    logic [31:0] out_buf_i;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        rready_i;
    logic        busy_o;
    logic        done_o;

    logic        tb_mode1;
    logic [31:0] reg_val;
    logic [31:0] nxt_val;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          strobe_cyc[$];
    int          nstrobe = 0;
    int          ndone = 0;
    int          done_cyc = 0;
    int          busy_rise = 0;
    int          busy_last = 0;
    logic        busy_prev = 1'b0;
    int          idx = 0;
    int          outst = 0;
    int          max_out = 0;

    output_load_seq #(
        .NUM_GROUPS(32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .load_mode_i(load_mode_i),
        .load_en_o  (load_en_o),
        .load_cnt_o (load_cnt_o),
        .load_mode_o(load_mode_o),
        .out_buf_i  (out_buf_i),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .rready_i   (rready_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output buffer: combinational in mode 1, one cycle late otherwise.
    assign out_buf_i = tb_mode1 ? (load_en_o ? 32'h1234_5678 : 32'd0)
                                : reg_val;

    initial begin
        reg_val = 32'd0;
        nxt_val = 32'd0;
        forever begin
            @(negedge clk);
            if (load_en_o) nxt_val = 32'hA000_0000 + {26'd0, load_cnt_o};
            @(posedge clk);
            #1 reg_val = nxt_val;
        end
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            outst = 0;
            busy_prev = 1'b0;
        end else begin
            if (busy_o && !busy_prev) begin
                idx = 0;
                busy_rise = cyc;
            end
            if (busy_o) busy_last = cyc;
            busy_prev = busy_o;
            if (load_en_o) begin
                check("load_cnt", {26'd0, load_cnt_o}, idx);
                idx++;
                nstrobe++;
                strobe_cyc.push_back(cyc);
                outst++;
            end
            if (rvalid_o && rready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%08h, expected none",
                             rdata_o);
                end else begin
                    check("rdata", rdata_o, exp_q.pop_front());
                end
                outst--;
            end
            if (outst > max_out) max_out = outst;
            if (done_o) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [1:0] m, output int t0);
        start_i = 1'b1;
        load_mode_i = m;
        t0 = cyc;
        tick(1);
        start_i = 1'b0;
        load_mode_i = 2'd0;
    endtask

    task automatic push_grp();
        for (int i = 0; i < 32; i++) exp_q.push_back(32'hA000_0000 + i);
    endtask

    task automatic wait_done(input int budget);
        int n;
        int base;
        n = 0;
        base = ndone;
        while (ndone == base && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (ndone == base) begin
            errors++;
            $display("FAIL done_timeout: got no done_o, expected within %0d",
                     budget);
        end
    endtask

    task automatic check_max();
        checks++;
        if (max_out > 4) begin
            errors++;
            $display("FAIL fifo_occupancy: got %0d, expected <= 4", max_out);
        end
    endtask

    initial begin
        int t0;
        int sb;
        int db;
        int c;
        int n;
        rst_ni = 1'b0;
        start_i = 1'b0;
        load_mode_i = 2'd0;
        rready_i = 1'b0;
        tb_mode1 = 1'b0;
        tick(3);
        check("rst_load_en", {31'd0, load_en_o}, 0);
        check("rst_load_cnt", {26'd0, load_cnt_o}, 0);
        check("rst_load_mode", {30'd0, load_mode_o}, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_rvalid", {31'd0, rvalid_o}, 0);
        check("rst_busy", {31'd0, busy_o}, 0);
        check("rst_done", {31'd0, done_o}, 0);
        rst_ni = 1'b1;
        tick(2);

        // Mode 2, free-flowing consumer.
        rready_i = 1'b1;
        push_grp();
        sb = nstrobe;
        db = ndone;
        start_seq(2'd2, t0);
        check("m2_first_strobe", {31'd0, load_en_o}, 1);
        wait_done(100);
        tick(4);
        check("m2_done_cycle", done_cyc - t0, 35);
        check("m2_busy_rise", busy_rise - t0, 1);
        check("m2_busy_last", busy_last - t0, 35);
        check("m2_strobes", nstrobe - sb, 32);
        check("m2_done_count", ndone - db, 1);
        check("m2_left", exp_q.size(), 0);
        check("m2_busy_end", {31'd0, busy_o}, 0);
        check("m2_mode_hold", {30'd0, load_mode_o}, 2);
        check("m2_cnt_hold", {26'd0, load_cnt_o}, 31);

        // Mode 1, single same-cycle capture.
        tb_mode1 = 1'b1;
        exp_q.push_back(32'h1234_5678);
        sb = nstrobe;
        db = ndone;
        start_seq(2'd1, t0);
        wait_done(20);
        tick(3);
        check("m1_done_cycle", done_cyc - t0, 3);
        check("m1_strobes", nstrobe - sb, 1);
        check("m1_done_count", ndone - db, 1);
        check("m1_left", exp_q.size(), 0);
        check("m1_mode", {30'd0, load_mode_o}, 1);
        tb_mode1 = 1'b0;

        // Mode 3 with the consumer stalled for 20 cycles.
        rready_i = 1'b0;
        push_grp();
        sb = nstrobe;
        db = ndone;
        start_seq(2'd3, t0);
        tick(19);
        check("m3_stall_strobes", nstrobe - sb, 4);
        check("m3_stall_en", {31'd0, load_en_o}, 0);
        check("m3_stall_cnt", {26'd0, load_cnt_o}, 3);
        check("m3_stall_rvalid", {31'd0, rvalid_o}, 1);
        check("m3_stall_rdata", rdata_o, 32'hA000_0000);
        rready_i = 1'b1;
        c = cyc;
        wait_done(200);
        tick(3);
        check("m3_resume_cycle", strobe_cyc[sb + 4], c + 1);
        check("m3_strobes", nstrobe - sb, 32);
        check("m3_done_count", ndone - db, 1);
        check("m3_left", exp_q.size(), 0);
        check_max();

        // Mode 2 with a 30% duty consumer.
        push_grp();
        sb = nstrobe;
        db = ndone;
        rready_i = 1'b0;
        start_seq(2'd2, t0);
        n = 0;
        while (ndone == db && n < 600) begin
            rready_i = ($urandom_range(0, 99) < 30);
            tick(1);
            n++;
        end
        rready_i = 1'b1;
        tick(3);
        check("bp_done_count", ndone - db, 1);
        check("bp_strobes", nstrobe - sb, 32);
        check("bp_left", exp_q.size(), 0);
        check_max();

        // Mode 0 start is ignored.
        sb = nstrobe;
        db = ndone;
        start_seq(2'd0, t0);
        tick(10);
        check("m0_strobes", nstrobe - sb, 0);
        check("m0_busy", {31'd0, busy_o}, 0);
        check("m0_done", ndone - db, 0);

        // Second start during an active sequence is ignored.
        push_grp();
        sb = nstrobe;
        db = ndone;
        start_seq(2'd2, t0);
        tick(4);
        start_i = 1'b1;
        load_mode_i = 2'd1;
        tick(1);
        start_i = 1'b0;
        load_mode_i = 2'd0;
        wait_done(100);
        tick(5);
        check("restart_strobes", nstrobe - sb, 32);
        check("restart_done", ndone - db, 1);
        check("restart_mode", {30'd0, load_mode_o}, 2);
        check("restart_left", exp_q.size(), 0);

        // Reset mid-sequence, then a clean rerun from index 0.
        push_grp();
        start_seq(2'd2, t0);
        tick(9);
        rst_ni = 1'b0;
        #1;
        check("mrst_load_en", {31'd0, load_en_o}, 0);
        check("mrst_load_cnt", {26'd0, load_cnt_o}, 0);
        check("mrst_load_mode", {30'd0, load_mode_o}, 0);
        check("mrst_rdata", rdata_o, 0);
        check("mrst_rvalid", {31'd0, rvalid_o}, 0);
        check("mrst_busy", {31'd0, busy_o}, 0);
        check("mrst_done", {31'd0, done_o}, 0);
        tick(2);
        rst_ni = 1'b1;
        tick(1);
        push_grp();
        sb = nstrobe;
        db = ndone;
        start_seq(2'd2, t0);
        wait_done(100);
        tick(3);
        check("post_rst_done_cycle", done_cyc - t0, 35);
        check("post_rst_strobes", nstrobe - sb, 32);
        check("post_rst_done", ndone - db, 1);
        check("post_rst_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1);
    end

endmodule

// File: doc/output_load_seq.md
# output_load_seq

Load sequencer sitting directly downstream of the output buffer stage. On a start request it walks the group index, drives `load_en`/`load_cnt` into the output buffer, captures the returned 32-bit `out_buf` words with the correct latency per load mode, and queues them in a small first-word-fall-through FIFO. The FIFO is drained by the RISC-V peripheral read path over a valid/ready handshake.

## Interface
- `NUM_GROUPS`, default 32: number of mapping groups walked in modes 2/3.
- `FIFO_DEPTH`, default 4: capture FIFO entries; power of 2, ≥2.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, asynchronous, active-low.
- `start_i`  in  1  single-cycle start request; sampled only in IDLE.
- `load_mode_i`  in  2  load mode, latched at start: 0 = none, 1 = read mode, 2/3 = mapping-group mode.
- `load_en_o`  out  1  load strobe to output buffer (`load_en_i`).
- `load_cnt_o`  out  6  group index to output buffer (`load_cnt_i`).
- `load_mode_o`  out  2  latched mode to output buffer (`before_load_mode_i`); holds its value after the sequence ends.
- `out_buf_i`  in  32  data from output buffer (`out_buf_o`).
- `rdata_o`  out  32  FIFO head word.
- `rvalid_o`  out  1  FIFO non-empty.
- `rready_i`  in  1  consumer accepts head word when `rvalid_o` is high.
- `busy_o`  out  1  high from start acceptance until `done_o`.
- `done_o`  out  1  one-cycle pulse when the last word is accepted.

## Operation
- FSM states:
  - IDLE:
    - `start_i` with mode 0 is ignored.
    - `start_i` with mode ≠ 0 latches the mode, clears the issue counter `icnt` and the accepted-word counter `acnt`, and moves to ISSUE.
  - ISSUE: raise `load_en_o` with `load_cnt_o` = `icnt` when `fifo_cnt + pend < FIFO_DEPTH`; otherwise hold `load_en_o` = 0 (stall).
    - Each issue increments `icnt`.
    - After issuing `N` strobes, go to DRAIN. `N` = 1 in mode 1, `NUM_GROUPS` in modes 2/3.
  - DRAIN: wait until `acnt == N`, pulse `done_o`, return to IDLE.
- Capture latency, per latched mode:
  - Mode 1: `out_buf_i` is valid in the same cycle as `load_en_o`; push it in that cycle.
  - Modes 2/3: `out_buf_i` is valid one cycle after `load_en_o`.
    - A 1-bit `pend` flag registers the issue.
    - Push `out_buf_i` in the cycle `pend` = 1.
- FIFO behaviour:
  - Registered storage with first-word-fall-through: `rdata_o` is the head entry.
  - A push and a pop in the same cycle are both legal; `fifo_cnt` is unchanged.
  - Overflow cannot occur because issue is gated by the space check. An implementation asserting on push-when-full is required.
- A pop is `rvalid_o & rready_i`. Each pop increments `acnt` while busy.
- Counters are sized so the 6-bit `load_cnt_o` never wraps: maximum issued index is `NUM_GROUPS-1` = 31.
- `start_i` while busy is ignored. There is no abort; only reset terminates a sequence.
- Reset (also mid-sequence):
  - FSM returns to IDLE; FIFO is emptied; `pend` and counters clear.
  - Any in-flight word is discarded.

## Timing
- Reset values: `load_en_o` 0, `load_cnt_o` 0, `load_mode_o` 0, `rdata_o` 0, `rvalid_o` 0, `busy_o` 0, `done_o` 0.
- `busy_o` is high from the cycle after `start_i` is accepted through the `done_o` cycle inclusive.
- Modes 2/3, FIFO empty, `rready_i` held high:
  - `start_i` at cycle 0 → `load_en_o`/`load_cnt_o`=0 at cycle 1.
  - Capture at cycle 2 → `rvalid_o` with word 0 at cycle 3.
  - One word per cycle thereafter; last word popped at cycle 34.
  - `done_o` at cycle 35.
- Mode 1: `start_i` at cycle 0 → `load_en_o` at 1 (capture same cycle) → `rvalid_o` at 2 → pop at 2 → `done_o` at 3.
- `done_o` is asserted the cycle after the final pop, and only then.
- With `rready_i` = 0 in modes 2/3: exactly `FIFO_DEPTH` strobes issue, then `load_en_o` stays 0 until a pop frees space.
  - Issue resumes the cycle after the pop.
- `load_cnt_o` holds the last issued index while `load_en_o` = 0.

## Test plan
- Mode 2, `out_buf_i` = 0xA000_0000 + `load_cnt` (delayed 1 cycle), `rready_i`=1 → 32 words 0xA000_0000..0xA000_001F in order, `done_o` at cycle 35, `busy_o` high for cycles 1–35.
- Mode 1, `out_buf_i` = 0x1234_5678 combinational on `load_en_o` → exactly one strobe with `load_cnt_o`=0, one word 0x1234_5678, `done_o` at cycle 3.
- Mode 3, `rready_i`=0 for 20 cycles then 1 → 4 strobes (cnt 0..3), `rvalid_o` held with 0xA000_0000, then all 32 words arrive in order with no loss or duplicate.
- Backpressure: random `rready_i` with 30% duty in mode 2 → word sequence matches reference counter, FIFO never exceeds 4 entries, no push-when-full.
- `start_i` with mode 0, and `start_i` pulsed again during an active mode-2 sequence → no strobes for the first; second has no effect (still 32 words, single `done_o`).
- `rst_ni` low at cycle 10 of a mode-2 sequence → all outputs return to reset values immediately. A new mode-2 start afterward yields words 0..31 from index 0.
